// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for one external memory port: fixed CPU priority, wait-state access, DMA anti-starvation.
// Optional feature ARB_BUS_LOCK_EN adds cpu_lock/dma_lock so one owner can keep the bus across two accesses.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate and latch the winner's request bundle
// ACCESS | memory strobes held for WAIT_CYCLES+1 cycles; read data captured in the last one
// RESP   | strobes low; one-cycle ack to the owner
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
`ifdef ARB_BUS_LOCK_EN
  input  logic        cpu_lock,
`endif
  output logic        cpu_gnt,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
`ifdef ARB_BUS_LOCK_EN
  input  logic        dma_lock,
`endif
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [7:0]  rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_wr;
  logic [3:0]  r_wait;
  logic [3:0]  r_starve;
`ifdef ARB_BUS_LOCK_EN
  logic        r_lock;
`endif

  logic        w_contested;
  logic        w_locked;
  logic        w_dma_win;
  logic [3:0]  w_starve_nxt;
  logic        w_sel_wr;
  logic [15:0] w_sel_addr;
  logic [7:0]  w_sel_wdata;

  always_comb begin
    w_contested = cpu_req & dma_req;
    w_locked    = 1'b0;
    w_dma_win   = dma_req & (~cpu_req |
                  ((STARVE_LIMIT != 0) && (r_starve == 4'(STARVE_LIMIT))));
`ifdef ARB_BUS_LOCK_EN
    // a locked owner that still requests keeps the bus regardless of priority
    if (r_lock && (r_owner ? dma_req : cpu_req)) begin
      w_locked  = 1'b1;
      w_dma_win = r_owner;
    end
`endif
    if (w_locked)
      w_starve_nxt = r_starve;
    else if (w_dma_win)
      w_starve_nxt = 4'd0;
    else if (w_contested && (r_starve != 4'hF))
      w_starve_nxt = r_starve + 4'd1;
    else
      w_starve_nxt = r_starve;
    w_sel_wr    = w_dma_win ? dma_wr    : cpu_wr;
    w_sel_addr  = w_dma_win ? dma_addr  : cpu_addr;
    w_sel_wdata = w_dma_win ? dma_wdata : cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_wr      <= 1'b0;
      r_wait    <= 4'd0;
      r_starve  <= 4'd0;
      cpu_gnt   <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_gnt   <= 1'b0;
      dma_ack   <= 1'b0;
      rdata     <= 8'd0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 8'd0;
      busy      <= 1'b0;
`ifdef ARB_BUS_LOCK_EN
      r_lock    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
`ifdef ARB_BUS_LOCK_EN
          r_lock <= 1'b0;
`endif
          if (cpu_req | dma_req) begin
            r_state   <= ACCESS;
            r_owner   <= w_dma_win;
            r_wr      <= w_sel_wr;
            r_wait    <= 4'(WAIT_CYCLES);
            r_starve  <= w_starve_nxt;
            mem_rd    <= ~w_sel_wr;
            mem_wr    <= w_sel_wr;
            mem_addr  <= w_sel_addr;
            mem_wdata <= w_sel_wdata;
            cpu_gnt   <= ~w_dma_win;
            dma_gnt   <= w_dma_win;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          if (r_wait == 4'd0) begin
            if (!r_wr)
              rdata <= mem_rdata;
            r_state   <= RESP;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 8'd0;
            cpu_ack   <= ~r_owner;
            dma_ack   <= r_owner;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          cpu_gnt <= 1'b0;
          dma_gnt <= 1'b0;
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          busy    <= 1'b0;
`ifdef ARB_BUS_LOCK_EN
          r_lock  <= r_owner ? dma_lock : cpu_lock;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
  localparam int WAIT_CYCLES  = 1;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr, cpu_gnt, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        dma_req, dma_wr, dma_gnt, dma_ack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  rdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
`ifdef ARB_BUS_LOCK_EN
  logic        cpu_lock, dma_lock;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.WAIT_CYCLES(WAIT_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef ARB_BUS_LOCK_EN
    .cpu_lock(cpu_lock),
`endif
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
`ifdef ARB_BUS_LOCK_EN
    .dma_lock(dma_lock),
`endif
    .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_cnt counts cycles left in the current access
  // (WAIT_CYCLES+2 at start, values >=2 are strobe cycles, 1 is the ack cycle, 0 is idle).
  logic        m_valid = 1'b0;
  int          m_cnt;
  int          m_starve;
  logic        m_owner, m_wr, m_lock, m_win;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1; m_cnt = 0; m_starve = 0; m_owner = 1'b0; m_wr = 1'b0;
      m_lock = 1'b0; m_addr = 16'd0; m_wdata = 8'd0; m_rdata = 8'd0;
    end else if (m_cnt == 0) begin
      if (cpu_req || dma_req) begin
        if (m_lock && (m_owner ? dma_req : cpu_req)) begin
          m_win = m_owner;
        end else if (cpu_req && dma_req) begin
          if (STARVE_LIMIT != 0 && m_starve == STARVE_LIMIT) begin
            m_win = 1'b1; m_starve = 0;
          end else begin
            m_win = 1'b0;
            if (m_starve < 15) m_starve++;
          end
        end else if (cpu_req) begin
          m_win = 1'b0;
        end else begin
          m_win = 1'b1; m_starve = 0;
        end
        m_owner = m_win;
        m_wr    = m_win ? dma_wr    : cpu_wr;
        m_addr  = m_win ? dma_addr  : cpu_addr;
        m_wdata = m_win ? dma_wdata : cpu_wdata;
        m_cnt   = WAIT_CYCLES + 2;
      end
      m_lock = 1'b0;
    end else begin
      if (m_cnt == 2 && !m_wr) m_rdata = mem_rdata;
`ifdef ARB_BUS_LOCK_EN
      if (m_cnt == 1) m_lock = m_owner ? dma_lock : cpu_lock;
`endif
      m_cnt--;
    end
  end

  logic e_acc, e_rsp;
  always @(negedge clk) begin
    if (m_valid) begin
      e_acc = (m_cnt >= 2);
      e_rsp = (m_cnt == 1);
      chk("m_busy",    32'(busy),    32'(m_cnt != 0));
      chk("m_cpu_gnt", 32'(cpu_gnt), 32'(m_cnt != 0 && !m_owner));
      chk("m_dma_gnt", 32'(dma_gnt), 32'(m_cnt != 0 && m_owner));
      chk("m_cpu_ack", 32'(cpu_ack), 32'(e_rsp && !m_owner));
      chk("m_dma_ack", 32'(dma_ack), 32'(e_rsp && m_owner));
      chk("m_mem_rd",  32'(mem_rd),  32'(e_acc && !m_wr));
      chk("m_mem_wr",  32'(mem_wr),  32'(e_acc && m_wr));
      chk("m_rdata",   32'(rdata),   32'(m_rdata));
      if (e_acc) begin
        chk("m_mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end else if (m_cnt == 0) begin
        chk("m_idle_addr",  32'(mem_addr),  32'd0);
        chk("m_idle_wdata", 32'(mem_wdata), 32'd0);
      end
    end
  end

  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'd0; cpu_wdata = 8'd0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_addr = 16'd0; dma_wdata = 8'd0;
    mem_rdata = 8'd0;
`ifdef ARB_BUS_LOCK_EN
    cpu_lock = 1'b0; dma_lock = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    reset = 1'b0;
  endtask

  function automatic logic cond_of(input int sel);
    case (sel)
      0:       return busy;
      1:       return cpu_ack;
      default: return dma_ack;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond_of(sel) && n < limit);
    chk(name, 32'(cond_of(sel)), 32'd1);
  endtask

  bit pend[2];

  task automatic drive(input int r, input logic req, input logic wr,
                       input logic [15:0] a, input logic [7:0] d);
    if (r == 0) begin
      cpu_req = req; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    end else begin
      dma_req = req; dma_wr = wr; dma_addr = a; dma_wdata = d;
    end
  endtask

  function automatic logic req_of(input int r);
    return (r == 0) ? cpu_req : dma_req;
  endfunction

  task automatic new_req(input int r);
    drive(r, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
    pend[r] = 1'b1;
  endtask

  task automatic rand_step();
    mem_rdata = 8'($urandom);
    reset = ($urandom_range(0, 199) == 0);
`ifdef ARB_BUS_LOCK_EN
    cpu_lock = ($urandom_range(0, 2) == 0);
    dma_lock = ($urandom_range(0, 2) == 0);
`endif
    for (int r = 0; r < 2; r++) begin
      if (pend[r] && !req_of(r) && m_cnt == 0) pend[r] = 1'b0;
      if (m_cnt == 1 && int'(m_owner) == r) begin
        if ($urandom_range(0, 1) == 1) new_req(r);
        else begin
          drive(r, 1'b0, 1'b0, 16'd0, 8'd0);
          pend[r] = 1'b0;
        end
      end else if (!pend[r]) begin
        if ($urandom_range(0, 2) == 0) new_req(r);
      end else if (m_cnt >= 2 && int'(m_owner) == r) begin
        // owner may change or drop its bundle mid-access; the latched copy must win
        if ($urandom_range(0, 3) == 0)
          drive(r, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                16'($urandom), 8'($urandom));
      end
    end
  endtask

  int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int seq[10];
  int ngr;
  logic prev_busy;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < 2; i++) pend[i] = 1'b0;
    do_reset();
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_gnt",   32'({cpu_gnt, dma_gnt}), 32'd0);
    chk("rst_strb",  32'({mem_rd, mem_wr}), 32'd0);

    // CPU read of 0x1234 returning 0xA5
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h1234; mem_rdata = 8'hA5;
    @(negedge clk); chk("rd_T_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rd_T1_mem_rd", 32'(mem_rd), 32'd1);
    chk("rd_T1_addr",   32'(mem_addr), 32'h1234);
    chk("rd_T1_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_T1_dma_gnt", 32'(dma_gnt), 32'd0);
    @(negedge clk);
    chk("rd_T2_mem_rd", 32'(mem_rd), 32'd1);
    chk("rd_T2_cpu_ack", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    chk("rd_T3_cpu_ack", 32'(cpu_ack), 32'd1);
    chk("rd_T3_mem_rd",  32'(mem_rd), 32'd0);
    chk("rd_T3_rdata",   32'(rdata), 32'hA5);
    chk("rd_T3_dma_gnt", 32'(dma_gnt), 32'd0);
    tick(); cpu_req = 1'b0;
    @(negedge clk); chk("rd_T4_cpu_ack", 32'(cpu_ack), 32'd0);

    // DMA write 0x8000 <- 0x3C
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 16'h8000; dma_wdata = 8'h3C;
    @(negedge clk);
    chk("wr_T1_mem_wr", 32'(mem_wr), 32'd1);
    chk("wr_T1_wdata",  32'(mem_wdata), 32'h3C);
    chk("wr_T1_addr",   32'(mem_addr), 32'h8000);
    chk("wr_T1_dma_gnt", 32'(dma_gnt), 32'd1);
    chk("wr_T1_cpu_gnt", 32'(cpu_gnt), 32'd0);
    @(negedge clk); chk("wr_T2_mem_wr", 32'(mem_wr), 32'd1);
    @(negedge clk);
    chk("wr_T3_dma_ack", 32'(dma_ack), 32'd1);
    chk("wr_T3_mem_wr",  32'(mem_wr), 32'd0);
    chk("wr_T3_rdata",   32'(rdata), 32'hA5);
    tick(); dma_req = 1'b0;
    @(negedge clk); chk("wr_T4_dma_ack", 32'(dma_ack), 32'd0);

    // both held continuously: four CPU wins then a forced DMA win
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0100; dma_req = 1'b1; dma_addr = 16'h0200;
    for (int i = 0; i < 10; i++) seq[i] = -1;
    ngr = 0; prev_busy = 1'b0;
    for (int i = 0; i < 80 && ngr < 10; i++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        seq[ngr] = int'(dma_gnt);
        ngr++;
      end
      prev_busy = busy;
    end
    chk("starve_grants", 32'(ngr), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

    // simultaneous requests: CPU first, DMA after CPU drops
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0011; dma_req = 1'b1; dma_addr = 16'h0022;
    wait_for(0, 10, "both_g1_seen");
    chk("both_g1_cpu", 32'(cpu_gnt), 32'd1);
    chk("both_g1_dma", 32'(dma_gnt), 32'd0);
    wait_for(1, 10, "both_cpu_ack_seen");
    tick(); cpu_req = 1'b0;
    wait_for(0, 10, "both_g2_seen");
    chk("both_g2_dma", 32'(dma_gnt), 32'd1);
    wait_for(2, 10, "both_dma_ack_seen");
    tick(); dma_req = 1'b0;

    // reset in the second ACCESS cycle of a CPU write
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h4242; cpu_wdata = 8'h99;
    @(negedge clk); chk("rw_T_busy", 32'(busy), 32'd0);
    @(negedge clk); chk("rw_T1_mem_wr", 32'(mem_wr), 32'd1);
    @(negedge clk); chk("rw_T2_mem_wr", 32'(mem_wr), 32'd1);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rw_rst_mem_wr",  32'(mem_wr), 32'd0);
    chk("rw_rst_busy",    32'(busy), 32'd0);
    chk("rw_rst_cpu_ack", 32'(cpu_ack), 32'd0);
    wait_for(1, 10, "rw_reack_seen");
    tick(); cpu_req = 1'b0;

`ifdef ARB_BUS_LOCK_EN
    // locked DMA read keeps the bus once more against a waiting CPU
    do_reset();
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 16'h7000; dma_lock = 1'b1;
    wait_for(0, 10, "lk_g1_seen");
    chk("lk_g1_dma", 32'(dma_gnt), 32'd1);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0500;
    wait_for(2, 10, "lk_ack1_seen");
    wait_for(0, 10, "lk_g2_seen");
    chk("lk_g2_dma", 32'(dma_gnt), 32'd1);
    dma_lock = 1'b0;
    wait_for(2, 10, "lk_ack2_seen");
    wait_for(0, 10, "lk_g3_seen");
    chk("lk_g3_cpu", 32'(cpu_gnt), 32'd1);
    wait_for(1, 10, "lk_cpu_ack_seen");
    tick(); cpu_req = 1'b0; dma_req = 1'b0;
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2; i++) pend[i] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rand_step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
